// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes, FSM states
// and the request-legality / store-lane helpers used at request acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LWAIT  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // Misaligned halfword/word, reserved size codes, or unsigned-size stores.
  function automatic logic req_error(input logic [2:0] funct3,
                                     input logic [1:0] addr_lo,
                                     input logic       is_store);
    logic err;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_BU:   err = is_store;
      F3_H:    err = addr_lo[0];
      F3_HU:   err = addr_lo[0] | is_store;
      F3_W:    err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] store_byte_en(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << addr_lo;
      F3_H:    be = 4'b0011 << addr_lo;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatting: picks the addressed byte/halfword lane of the
// memory word and sign- or zero-extends it according to the size code.
module lsu_load_align (
  input  logic [31:0] mem_data,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);
  import lsu_pkg::*;

  logic [31:0] shifted_s;

  // Addressed lane moved down to bit 0; word loads are always aligned.
  assign shifted_s = mem_data >> {addr_lo, 3'b000};

  // Size/sign selection of the aligned lane.
  always_comb begin
    rdata = 32'h0000_0000;
    case (funct3)
      F3_B:    rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    rdata = shifted_s;
      F3_BU:   rdata = {24'h00_0000, shifted_s[7:0]};
      F3_HU:   rdata = {16'h0000, shifted_s[15:0]};
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core and a synchronous
// word-wide data memory with byte enables.
module load_store_unit #(
  parameter int MEM_AW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              in_req_valid,
  output logic              out_req_ready,
  input  logic              in_req_is_store,
  input  logic [2:0]        in_req_funct3,
  input  logic [31:0]       in_req_addr,
  input  logic [31:0]       in_req_wdata,
  output logic              out_resp_valid,
  output logic [31:0]       out_resp_rdata,
  output logic              out_resp_err,
  output logic [MEM_AW-1:0] out_mem_addr,
  output logic              out_mem_re_web,
  output logic [31:0]       out_mem_write_data,
  output logic [3:0]        out_mem_byte_en,
  input  logic [31:0]       in_mem_data
);
  import lsu_pkg::*;

  lsu_state_e        state_r;
  lsu_state_e        state_s;
  logic              ready_r;
  logic              resp_valid_r;
  logic              resp_err_r;
  logic [31:0]       resp_rdata_r;
  logic [MEM_AW-1:0] mem_addr_r;
  logic              mem_re_web_r;
  logic [3:0]        mem_byte_en_r;
  logic [31:0]       mem_write_data_r;
  logic              req_is_store_r;
  logic [2:0]        req_funct3_r;
  logic [1:0]        req_addr_lo_r;
  logic              accept_s;
  logic              req_err_s;
  logic [31:0]       load_data_s;
  logic              unused_addr_s;

  // Address bits above the memory window are deliberately ignored.
  assign unused_addr_s = ^in_req_addr[31:MEM_AW+2];

  assign accept_s  = in_req_valid & ready_r;
  assign req_err_s = req_error(in_req_funct3, in_req_addr[1:0], in_req_is_store);

  lsu_load_align u_load_align (
    .mem_data (in_mem_data),
    .addr_lo  (req_addr_lo_r),
    .funct3   (req_funct3_r),
    .rdata    (load_data_s)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = req_err_s ? RESP : ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = req_is_store_r ? RESP : LWAIT;
      LWAIT:   state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered outputs: memory strobes are set up on the accept edge so they
  // are valid for exactly the ACCESS cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ready_r          <= 1'b1;
      resp_valid_r     <= 1'b0;
      resp_err_r       <= 1'b0;
      resp_rdata_r     <= 32'h0000_0000;
      mem_addr_r       <= {MEM_AW{1'b0}};
      mem_re_web_r     <= 1'b1;
      mem_byte_en_r    <= 4'b0000;
      mem_write_data_r <= 32'h0000_0000;
      req_is_store_r   <= 1'b0;
      req_funct3_r     <= 3'b000;
      req_addr_lo_r    <= 2'b00;
    end else begin
      ready_r      <= (state_s == IDLE);
      resp_valid_r <= (state_s == RESP);

      if (accept_s) begin
        req_is_store_r <= in_req_is_store;
        req_funct3_r   <= in_req_funct3;
        req_addr_lo_r  <= in_req_addr[1:0];
        mem_addr_r     <= in_req_addr[MEM_AW+1:2];
      end

      if (accept_s && !req_err_s) begin
        mem_re_web_r     <= ~in_req_is_store;
        mem_byte_en_r    <= in_req_is_store ? store_byte_en(in_req_funct3, in_req_addr[1:0])
                                            : 4'b0000;
        mem_write_data_r <= in_req_is_store ? (in_req_wdata << {in_req_addr[1:0], 3'b000})
                                            : 32'h0000_0000;
      end else begin
        mem_re_web_r     <= 1'b1;
        mem_byte_en_r    <= 4'b0000;
        mem_write_data_r <= 32'h0000_0000;
      end

      if (accept_s && req_err_s) begin
        resp_rdata_r <= 32'h0000_0000;
        resp_err_r   <= 1'b1;
      end else if ((state_r == ACCESS) && req_is_store_r) begin
        resp_rdata_r <= 32'h0000_0000;
        resp_err_r   <= 1'b0;
      end else if (state_r == LWAIT) begin
        resp_rdata_r <= load_data_s;
        resp_err_r   <= 1'b0;
      end
    end
  end

  assign out_req_ready      = ready_r;
  assign out_resp_valid     = resp_valid_r;
  assign out_resp_err       = resp_err_r;
  assign out_resp_rdata     = resp_rdata_r;
  assign out_mem_addr       = mem_addr_r;
  assign out_mem_re_web     = mem_re_web_r;
  assign out_mem_byte_en    = mem_byte_en_r;
  assign out_mem_write_data = mem_write_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference memory predicts
// every response; a synchronous word memory model serves the DUT.
module tb_load_store_unit;

  localparam int MEM_AW = 10;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              in_req_valid;
  logic              out_req_ready;
  logic              in_req_is_store;
  logic [2:0]        in_req_funct3;
  logic [31:0]       in_req_addr;
  logic [31:0]       in_req_wdata;
  logic              out_resp_valid;
  logic [31:0]       out_resp_rdata;
  logic              out_resp_err;
  logic [MEM_AW-1:0] out_mem_addr;
  logic              out_mem_re_web;
  logic [31:0]       out_mem_write_data;
  logic [3:0]        out_mem_byte_en;
  logic [31:0]       in_mem_data;

  load_store_unit #(.MEM_AW(MEM_AW)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .in_req_valid       (in_req_valid),
    .out_req_ready      (out_req_ready),
    .in_req_is_store    (in_req_is_store),
    .in_req_funct3      (in_req_funct3),
    .in_req_addr        (in_req_addr),
    .in_req_wdata       (in_req_wdata),
    .out_resp_valid     (out_resp_valid),
    .out_resp_rdata     (out_resp_rdata),
    .out_resp_err       (out_resp_err),
    .out_mem_addr       (out_mem_addr),
    .out_mem_re_web     (out_mem_re_web),
    .out_mem_write_data (out_mem_write_data),
    .out_mem_byte_en    (out_mem_byte_en),
    .in_mem_data        (in_mem_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] mem [0:(1<<MEM_AW)-1];
  logic [7:0]  ref_mem [0:(4<<MEM_AW)-1];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Synchronous data memory: byte-enabled write, registered read.
  always @(posedge i_clk) begin
    if (!out_mem_re_web) begin
      for (int b = 0; b < 4; b++) begin
        if (out_mem_byte_en[b]) mem[out_mem_addr][8*b +: 8] <= out_mem_write_data[8*b +: 8];
      end
    end
    in_mem_data <= mem[out_mem_addr];
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%08h expected=%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic ref_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    if (sz == 0 || f3 == 3'b110) return 1'b1;
    if (st && f3[2]) return 1'b1;
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int          sz = size_of(f3);
    int          base = int'(a[MEM_AW+1:0]);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
    if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // Drive one request from a falling edge; returns on the falling edge after acceptance.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, input bit track,
                        output int acc);
    int   waited = 0;
    exp_t e;
    in_req_valid    = 1'b1;
    in_req_is_store = st;
    in_req_funct3   = f3;
    in_req_addr     = a;
    in_req_wdata    = wd;
    while (!out_req_ready && waited < 50) begin
      @(negedge i_clk);
      waited++;
    end
    if (!out_req_ready) begin
      check32("accept_timeout", {31'h0, out_req_ready}, 32'h1);
      in_req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    e.err   = ref_err(st, f3, a);
    e.rdata = (e.err || st) ? 32'h0 : ref_load(f3, a);
    // Response is visible on the falling edge (latency-1) clocks after the accepting edge.
    e.cyc   = acc + (e.err ? 1 : (st ? 2 : 3)) - 1;
    if (track) begin
      exp_q.push_back(e);
      if (st && !e.err) begin
        for (int k = 0; k < size_of(f3); k++)
          ref_mem[int'(a[MEM_AW+1:0]) + k] = wd[8*k +: 8];
      end
    end
    @(negedge i_clk);
    if (!hold) in_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check32("drain_pending", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_resp_valid"}, {31'h0, out_resp_valid}, 32'h0);
    check32({tag, "_resp_err"},   {31'h0, out_resp_err},   32'h0);
    check32({tag, "_resp_rdata"}, out_resp_rdata,          32'h0);
    check32({tag, "_mem_addr"},   32'(out_mem_addr),       32'h0);
    check32({tag, "_re_web"},     {31'h0, out_mem_re_web}, 32'h1);
    check32({tag, "_byte_en"},    {28'h0, out_mem_byte_en}, 32'h0);
    check32({tag, "_wdata"},      out_mem_write_data,      32'h0);
  endtask

  // Monitor: every response pops the scoreboard and must arrive on the predicted cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (out_resp_valid) begin
        last_rdata = out_resp_rdata;
        check32("resp_mem_idle", {27'h0, out_mem_re_web, out_mem_byte_en}, 32'h10);
        if (exp_q.size() == 0) begin
          check32("spurious_resp", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check32("resp_rdata", out_resp_rdata, e.rdata);
          check32("resp_err", {31'h0, out_resp_err}, {31'h0, e.err});
          check32("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    int a1;
    int a2;
    int acc;
    logic [2:0] f3;
    i_rst = 1'b0;
    in_req_valid = 1'b0;
    in_req_is_store = 1'b0;
    in_req_funct3 = 3'b000;
    in_req_addr = 32'h0;
    in_req_wdata = 32'h0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("por");
    i_rst = 1'b1;
    #1 check32("ready_after_release", {31'h0, out_req_ready}, 32'h1);

    // Initialise the 16-word working region through the DUT.
    for (int w = 0; w < 16; w++) do_req(1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0, 1'b1, acc);

    do_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, acc);
    check32("sw_mem_addr", 32'(out_mem_addr), 32'd4);
    check32("sw_re_web", {31'h0, out_mem_re_web}, 32'h0);
    check32("sw_byte_en", {28'h0, out_mem_byte_en}, 32'hF);
    check32("sw_wdata", out_mem_write_data, 32'hDEAD_BEEF);
    check32("access_not_ready", {31'h0, out_req_ready}, 32'h0);

    do_req(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 1'b0, 1'b1, acc);
    check32("sb_mem_addr", 32'(out_mem_addr), 32'd4);
    check32("sb_byte_en", {28'h0, out_mem_byte_en}, 32'h8);
    check32("sb_wdata", out_mem_write_data, 32'hA500_0000);

    do_req(1'b1, 3'b010, 32'h0000_0010, 32'h1280_3456, 1'b0, 1'b1, acc);
    do_req(1'b0, 3'b000, 32'h0000_0012, 32'h0, 1'b0, 1'b1, acc);
    drain();
    check32("lb_value", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h0000_0012, 32'h0, 1'b0, 1'b1, acc);
    drain();
    check32("lbu_value", last_rdata, 32'h0000_0080);

    do_req(1'b0, 3'b001, 32'h0000_0011, 32'h0, 1'b0, 1'b1, acc);
    check32("lh_mis_no_access", {27'h0, out_mem_re_web, out_mem_byte_en}, 32'h10);
    do_req(1'b0, 3'b011, 32'h0000_0010, 32'h0, 1'b0, 1'b1, acc);
    check32("f3_011_no_access", {27'h0, out_mem_re_web, out_mem_byte_en}, 32'h10);
    drain();

    do_req(1'b0, 3'b010, 32'h0000_0008, 32'h0, 1'b1, 1'b1, a1);
    do_req(1'b0, 3'b101, 32'h0000_0006, 32'h0, 1'b0, 1'b1, a2);
    check32("b2b_spacing", 32'(a2 - a1), 32'd4);
    drain();

    // Abort a load while it waits for memory data.
    do_req(1'b0, 3'b010, 32'h0000_0004, 32'h0, 1'b0, 1'b0, acc);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    #1 check32("abort_ready", {31'h0, out_req_ready}, 32'h1);
    repeat (4) @(negedge i_clk);

    for (int i = 0; i < 300; i++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      do_req(1'($urandom_range(0, 1)), f3,
             ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
             $urandom, 1'($urandom_range(0, 1)), 1'b1, acc);
      if ($urandom_range(0, 3) == 0) begin
        in_req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge i_clk);
      end
    end
    in_req_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
